mouse_receiver: RTL

- Host-side PS/2 device-to-host byte receiver.
- Sits directly beside the mouse transmitter on the same bidirectional PS/2 lines and feeds received bytes (ACK 0xFA, status/X/Y packets) to the mouse master state machine.
- Samples 11-bit frames on mouse-clock falling edges, checks framing, and presents each byte with a one-cycle valid strobe and an error code.

---
 rtl/mouse_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 87 ++++++++
 rtl/mouse_receiver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse host-side receiver.
// Frame layout: start(0), 8 data bits LSB-first, odd parity, stop(1).
`timescale 1ns/1ps
package mouse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_DONE   = 3'd4
    } rx_state_e;

    localparam int ERR_PARITY_BIT         = 0;
    localparam int ERR_STOP_BIT           = 1;
    localparam int PS2_DATA_BITS          = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;
    localparam int DEFAULT_FILTER_CYCLES  = 8;

    // Odd parity holds when data bits plus parity bit contain an odd count of ones.
    function automatic logic odd_parity_ok(
        input logic [PS2_DATA_BITS-1:0] data,
        input logic                     parity
    );
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the PS/2 clock/data lines and flags mouse-clock falling edges.
// Optional clock-line glitch filter enabled by MOUSE_RX_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module ps2_line_sync #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_fe,
    output logic data_sync
);

    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("FILTER_CYCLES must be at least 1");
    end

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic clk_line;

    always_comb begin
        clk_meta_d  = clk_in;
        clk_sync_d  = clk_meta_q;
        data_meta_d = data_in;
        data_sync_d = data_meta_q;
        clk_prev_d  = clk_line;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

`ifdef MOUSE_RX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    // Follow the synced line only once it has disagreed for FILTER_CYCLES cycles.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign clk_line = filt_q;
`else
    assign clk_line = clk_sync_q;
`endif

    assign clk_fe    = clk_prev_q & ~clk_line;
    assign data_sync = data_sync_q;

endmodule

// File: rtl/mouse_receiver.sv
// Host-side PS/2 device-to-host byte receiver with framing checks and timeout.
// Build option MOUSE_RX_GLITCH_FILTER_EN adds a clock-line glitch filter.
`timescale 1ns/1ps
module mouse_receiver
    import mouse_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FILTER_CYCLES  = DEFAULT_FILTER_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    if (TIMEOUT_CYCLES < 2 || CLK_FREQ_HZ < 1) begin : g_bad_params
        $error("TIMEOUT_CYCLES must be >= 2 and CLK_FREQ_HZ positive");
    end

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = $clog2(PS2_DATA_BITS) + 1;

    logic clk_fe;
    logic data_sync;

    ps2_line_sync #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync (
        .clk       (CLK),
        .rst       (RESET),
        .clk_in    (CLK_MOUSE_IN),
        .data_in   (DATA_MOUSE_IN),
        .clk_fe    (clk_fe),
        .data_sync (data_sync)
    );

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic [1:0]             err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   in_frame;
    logic                   timeout;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = '0;
        byte_d    = byte_q;
        err_d     = err_q;
        ready_d   = 1'b0;

        in_frame = (state_q == ST_DATA) || (state_q == ST_PARITY)
                || (state_q == ST_STOP);
        timeout  = in_frame && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

        if (in_frame && !clk_fe) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (READ_ENABLE && clk_fe && !data_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (clk_fe) begin
                    shift_d   = {data_sync, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(PS2_DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fe) begin
                    parity_d = data_sync;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fe) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    byte_d  = shift_q;
                    err_d[ERR_PARITY_BIT] = ~odd_parity_ok(shift_q, parity_q);
                    err_d[ERR_STOP_BIT]   = ~data_sync;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing the lines to the transmitter outranks everything, even a stop edge.
        if (state_q != ST_IDLE && !READ_ENABLE) begin
            state_d  = ST_IDLE;
            ready_d  = 1'b0;
            byte_d   = byte_q;
            err_d    = err_q;
            to_cnt_d = '0;
        end else if (timeout && !clk_fe) begin
            state_d  = ST_IDLE;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
            byte_q    <= 8'h00;
            err_q     <= 2'b00;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = ready_q;

endmodule
